// File: rtl/phys_step_scheduler.sv
// Frame-synchronous position integrator for player 1, player 2 and the ball.
// Each frame pulse steps the three objects through one shared integrator slot
// apiece, clamps them to the playfield and publishes a coherent snapshot.
// Optional feature macro: PHYS_BOUNCE_EN (ball velocity reflects on clamped axes).
module phys_step_scheduler #(
  parameter logic [15:0] XMAX = 16'd639,
  parameter logic [15:0] YMAX = 16'd479
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        vel_wr_en,
  input  logic [1:0]  vel_wr_sel,
  input  logic [31:0] vel_wr_data,
  input  logic        overrun_clr,
  output logic [31:0] p1_pos,
  output logic [31:0] p2_pos,
  output logic [31:0] b1_pos,
  output logic [31:0] p1_vel,
  output logic [31:0] p2_vel,
  output logic [31:0] b1_vel,
  output logic        busy,
  output logic        snap_valid,
  output logic        overrun
);

  typedef enum logic [2:0] {StIdle, StUpd0, StUpd1, StUpd2, StSnap} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_pos      [3];
  logic [31:0] r_vel      [3];
  logic [31:0] r_snap_pos [3];
  logic [31:0] r_snap_vel [3];
  logic        r_busy;
  logic        r_snap_valid;
  logic        r_overrun;

  logic        w_upd;
  logic [1:0]  w_slot;
  logic        w_bypass;
  logic [31:0] w_pos_in;
  logic [31:0] w_vel_in;
  logic [16:0] w_sum_x;
  logic [16:0] w_sum_y;
  logic        w_hi_x;
  logic        w_hi_y;
  logic [15:0] w_new_x;
  logic [15:0] w_new_y;
  logic [31:0] w_pos_upd;
  logic [31:0] w_vel_upd;

`ifdef PHYS_BOUNCE_EN
  // Two's complement negation saturating the one unrepresentable case.
  function automatic logic [15:0] sat_neg(input logic [15:0] v);
    return (v == 16'h8000) ? 16'h7FFF : (~v + 16'd1);
  endfunction
`endif

  // Next-state logic for the step sequence.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (frame_start) w_state_next = StUpd0;
      StUpd0:  w_state_next = StUpd1;
      StUpd1:  w_state_next = StUpd2;
      StUpd2:  w_state_next = StSnap;
      StSnap:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Select the object served by the integrator this cycle, with write bypass.
  always_comb begin
    w_upd  = 1'b1;
    w_slot = 2'd0;
    case (r_state)
      StUpd0:  w_slot = 2'd0;
      StUpd1:  w_slot = 2'd1;
      StUpd2:  w_slot = 2'd2;
      default: w_upd  = 1'b0;
    endcase
    w_bypass = w_upd && vel_wr_en && (vel_wr_sel == w_slot);
    w_pos_in = r_pos[0];
    w_vel_in = r_vel[0];
    case (w_slot)
      2'd1:    begin w_pos_in = r_pos[1]; w_vel_in = r_vel[1]; end
      2'd2:    begin w_pos_in = r_pos[2]; w_vel_in = r_vel[2]; end
      default: ;
    endcase
    if (w_bypass) w_vel_in = vel_wr_data;
  end

  // Shared integrator: 17-bit signed sum per axis, clamped to [0, max].
  always_comb begin
    w_sum_x = {1'b0, w_pos_in[31:16]} + {w_vel_in[31], w_vel_in[31:16]};
    w_sum_y = {1'b0, w_pos_in[15:0]}  + {w_vel_in[15], w_vel_in[15:0]};
    w_hi_x  = !w_sum_x[16] && (w_sum_x[15:0] > XMAX);
    w_hi_y  = !w_sum_y[16] && (w_sum_y[15:0] > YMAX);
    w_new_x = w_sum_x[16] ? 16'd0 : (w_hi_x ? XMAX : w_sum_x[15:0]);
    w_new_y = w_sum_y[16] ? 16'd0 : (w_hi_y ? YMAX : w_sum_y[15:0]);
    w_pos_upd = {w_new_x, w_new_y};
    w_vel_upd = w_vel_in;
`ifdef PHYS_BOUNCE_EN
    // Only the ball slot reflects; players always keep their velocity.
    if (r_state == StUpd2) begin
      if (w_sum_x[16] || w_hi_x) w_vel_upd[31:16] = sat_neg(w_vel_in[31:16]);
      if (w_sum_y[16] || w_hi_y) w_vel_upd[15:0]  = sat_neg(w_vel_in[15:0]);
    end
`endif
  end

  // FSM state, status flags and overrun bookkeeping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= StIdle;
      r_busy       <= 1'b0;
      r_snap_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_busy       <= (w_state_next != StIdle);
      r_snap_valid <= (r_state == StSnap);
      // A new overrun beats a simultaneous clear.
      if (frame_start && (r_state != StIdle)) r_overrun <= 1'b1;
      else if (overrun_clr)                    r_overrun <= 1'b0;
    end
  end

  // Object state: integrator slot owns pos/vel[k] in UPDk, otherwise host writes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 3; i++) begin
        r_pos[i] <= 32'h0;
        r_vel[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_upd && (w_slot == 2'(i))) begin
          r_pos[i] <= w_pos_upd;
          r_vel[i] <= w_vel_upd;
        end else if (vel_wr_en && (vel_wr_sel == 2'(i))) begin
          r_vel[i] <= vel_wr_data;
        end
      end
    end
  end

  // Snapshot captures pos/vel as they stand entering SNAP.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 3; i++) begin
        r_snap_pos[i] <= 32'h0;
        r_snap_vel[i] <= 32'h0;
      end
    end else if (r_state == StSnap) begin
      for (int i = 0; i < 3; i++) begin
        r_snap_pos[i] <= r_pos[i];
        r_snap_vel[i] <= r_vel[i];
      end
    end
  end

  assign p1_pos     = r_snap_pos[0];
  assign p2_pos     = r_snap_pos[1];
  assign b1_pos     = r_snap_pos[2];
  assign p1_vel     = r_snap_vel[0];
  assign p2_vel     = r_snap_vel[1];
  assign b1_vel     = r_snap_vel[2];
  assign busy       = r_busy;
  assign snap_valid = r_snap_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_phys_step_scheduler.sv
// Directed bench for phys_step_scheduler; expectations follow the build's
// PHYS_BOUNCE_EN setting. Tasks start and end 1 time unit after a rising edge.
module tb_phys_step_scheduler;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        vel_wr_en = 1'b0;
  logic [1:0]  vel_wr_sel = 2'd0;
  logic [31:0] vel_wr_data = 32'h0;
  logic        overrun_clr = 1'b0;
  logic [31:0] p1_pos, p2_pos, b1_pos, p1_vel, p2_vel, b1_vel;
  logic        busy, snap_valid, overrun;

  int vectors = 0;
  int miscompares = 0;

  phys_step_scheduler #(.XMAX(16'd639), .YMAX(16'd479)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .vel_wr_en   (vel_wr_en),
    .vel_wr_sel  (vel_wr_sel),
    .vel_wr_data (vel_wr_data),
    .overrun_clr (overrun_clr),
    .p1_pos      (p1_pos),
    .p2_pos      (p2_pos),
    .b1_pos      (b1_pos),
    .p1_vel      (p1_vel),
    .p2_vel      (p2_vel),
    .b1_vel      (b1_vel),
    .busy        (busy),
    .snap_valid  (snap_valid),
    .overrun     (overrun)
  );

  always #10 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic wr_vel(input logic [1:0] sel, input logic [31:0] data);
    vel_wr_en = 1'b1;
    vel_wr_sel = sel;
    vel_wr_data = data;
    tick();
    vel_wr_en = 1'b0;
  endtask

  // Pulse frame_start and return in cycle N+5, when the snapshot is visible.
  task automatic run_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    logic [191:0] all_out;
    tick();
    tick();
    @(negedge Clk);
    all_out = {p1_pos, p2_pos, b1_pos, p1_vel, p2_vel, b1_vel};
    vectors++;
    if (all_out !== 192'h0 || {busy, snap_valid, overrun} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_state got out=%h flags=%b want 0/000", all_out,
               {busy, snap_valid, overrun});
    end
    tick();
    Reset = 1'b0;
    tick();
    frame_start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      frame_start = 1'b0;
      @(negedge Clk);
      vectors++;
      if (busy !== (k <= 4) || snap_valid !== (k == 5)) begin
        miscompares++;
        $display("FAIL zero_frame_timing N+%0d got busy=%b snap=%b want busy=%b snap=%b",
                 k, busy, snap_valid, k <= 4, k == 5);
      end
    end
    all_out = {p1_pos, p2_pos, b1_pos, p1_vel, p2_vel, b1_vel};
    vectors++;
    if (all_out !== 192'h0) begin
      miscompares++;
      $display("FAIL zero_frame_outputs got %h want 0", all_out);
    end
    tick();
    vectors++;
    if (snap_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL snap_valid_one_cycle got %b want 0", snap_valid);
    end
  endtask

  task automatic test_p1_step();
    do_reset();
    wr_vel(2'd0, 32'h0064_0032);
    run_frame();
    vectors++;
    if (p1_pos !== 32'h0064_0032) begin
      miscompares++;
      $display("FAIL p1_setup_pos got %h want 00640032", p1_pos);
    end
    wr_vel(2'd0, 32'h0005_FFFD);
    vectors++;
    if (p1_vel !== 32'h0064_0032) begin
      miscompares++;
      $display("FAIL p1_vel_before_snap got %h want 00640032", p1_vel);
    end
    run_frame();
    vectors++;
    if (p1_pos !== 32'h0069_002F || p1_vel !== 32'h0005_FFFD) begin
      miscompares++;
      $display("FAIL p1_step got pos=%h vel=%h want 0069002f/0005fffd", p1_pos, p1_vel);
    end
    vectors++;
    if (p2_pos !== 32'h0 || b1_pos !== 32'h0) begin
      miscompares++;
      $display("FAIL p1_step_others got p2=%h b1=%h want 0/0", p2_pos, b1_pos);
    end
  endtask

  task automatic test_clamp();
    logic [31:0] exp_vel;
    do_reset();
    wr_vel(2'd2, 32'h027D_0002);
    wr_vel(2'd1, 32'h0000_01F4);
    run_frame();
    vectors++;
    if (b1_pos !== 32'h027D_0002) begin
      miscompares++;
      $display("FAIL ball_setup_pos got %h want 027d0002", b1_pos);
    end
    vectors++;
    if (p2_pos !== 32'h0000_01DF || p2_vel !== 32'h0000_01F4) begin
      miscompares++;
      $display("FAIL p2_ymax_clamp got pos=%h vel=%h want 000001df/000001f4", p2_pos, p2_vel);
    end
    wr_vel(2'd2, 32'h0004_FFFB);
    run_frame();
`ifdef PHYS_BOUNCE_EN
    exp_vel = 32'hFFFC_0005;
`else
    exp_vel = 32'h0004_FFFB;
`endif
    vectors++;
    if (b1_pos !== 32'h027F_0000 || b1_vel !== exp_vel) begin
      miscompares++;
      $display("FAIL ball_corner got pos=%h vel=%h want 027f0000/%h", b1_pos, b1_vel, exp_vel);
    end
    vectors++;
    if (p2_pos !== 32'h0000_01DF || p2_vel !== 32'h0000_01F4) begin
      miscompares++;
      $display("FAIL player_no_bounce got pos=%h vel=%h want 000001df/000001f4", p2_pos, p2_vel);
    end
    wr_vel(2'd2, 32'h8000_0000);
    run_frame();
`ifdef PHYS_BOUNCE_EN
    exp_vel = 32'h7FFF_0000;
`else
    exp_vel = 32'h8000_0000;
`endif
    vectors++;
    if (b1_pos !== 32'h0000_0000 || b1_vel !== exp_vel) begin
      miscompares++;
      $display("FAIL ball_min_vel got pos=%h vel=%h want 00000000/%h", b1_pos, b1_vel, exp_vel);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    vel_wr_en = 1'b1;
    vel_wr_sel = 2'd1;
    vel_wr_data = 32'h000A_0000;
    tick();
    vel_wr_en = 1'b0;
    tick();
    tick();
    vectors++;
    if (p2_pos !== 32'h000A_0000 || p2_vel !== 32'h000A_0000 || snap_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_upd1 got pos=%h vel=%h snap=%b want 000a0000/000a0000/1",
               p2_pos, p2_vel, snap_valid);
    end
  endtask

  task automatic test_snap_write();
    do_reset();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    tick();
    wr_vel(2'd0, 32'h0007_0007);
    vectors++;
    if (p1_vel !== 32'h0 || p1_pos !== 32'h0 || snap_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL snap_cycle_write got pos=%h vel=%h snap=%b want 0/0/1",
               p1_pos, p1_vel, snap_valid);
    end
    run_frame();
    vectors++;
    if (p1_pos !== 32'h0007_0007 || p1_vel !== 32'h0007_0007) begin
      miscompares++;
      $display("FAIL snap_write_next got pos=%h vel=%h want 00070007/00070007", p1_pos, p1_vel);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    vectors++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_n1 got ovr=%b busy=%b want 0/1", overrun, busy);
    end
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    vectors++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set got ovr=%b busy=%b want 1/1", overrun, busy);
    end
    tick();
    tick();
    vectors++;
    if (snap_valid !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_seq_done got snap=%b busy=%b want 1/0", snap_valid, busy);
    end
    tick();
    vectors++;
    if (snap_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_no_restart got snap=%b busy=%b want 0/0", snap_valid, busy);
    end
    frame_start = 1'b1;
    tick();
    overrun_clr = 1'b1;
    tick();
    frame_start = 1'b0;
    overrun_clr = 1'b0;
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set_wins got %b want 1", overrun);
    end
    repeat (3) tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear got %b want 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_vel(2'd0, 32'h0003_0003);
    run_frame();
    vectors++;
    if (p1_pos !== 32'h0003_0003) begin
      miscompares++;
      $display("FAIL mid_setup got %h want 00030003", p1_pos);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    vectors++;
    if ({p1_pos, p1_vel, b1_pos} !== 96'h0 || busy !== 1'b0 || snap_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got p1=%h/%h busy=%b snap=%b want 0/0/0/0",
               p1_pos, p1_vel, busy, snap_valid);
    end
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if (snap_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset_quiet cyc%0d got snap=%b busy=%b want 0/0",
                 k, snap_valid, busy);
      end
    end
    wr_vel(2'd0, 32'h0003_0003);
    run_frame();
    vectors++;
    if (p1_pos !== 32'h0003_0003 || snap_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_rerun got pos=%h snap=%b want 00030003/1", p1_pos, snap_valid);
    end
  endtask

  initial begin
    test_reset();
    test_p1_step();
    test_clamp();
    test_bypass();
    test_snap_write();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phys_step_scheduler.md
# phys_step_scheduler

Frame-synchronous scheduler for the shared position integrator of the three game objects (player 1, player 2, ball). On each frame pulse it steps the objects through one integrator slot each, clamps them to the playfield, and publishes a coherent snapshot onto the 32-bit position/velocity PIO exports read by the NIOS. It also arbitrates velocity writes from the keycode/game logic against its own integration slots.

## Interface

Parameters:
- XMAX, 16'd639: maximum x position (inclusive).
- YMAX, 16'd479: maximum y position (inclusive).

Ports:
- Clk  in  1  system clock (50 MHz domain).
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  single-cycle frame pulse (vsync-derived).
- vel_wr_en  in  1  velocity write strobe.
- vel_wr_sel  in  2  target object: 0 p1, 1 p2, 2 ball, 3 ignored.
- vel_wr_data  in  32  {vx[31:16], vy[15:0]}, signed two's complement.
- overrun_clr  in  1  clears the overrun flag.
- p1_pos, p2_pos, b1_pos  out  32  snapshot positions {x[31:16], y[15:0]}, unsigned.
- p1_vel, p2_vel, b1_vel  out  32  snapshot velocities, same packing as vel_wr_data.
- busy  out  1  high while a step sequence is in progress.
- snap_valid  out  1  one-cycle pulse when the snapshot outputs update.
- overrun  out  1  sticky: frame_start arrived while busy.

## Operation

- Internal state: pos[0..2], vel[0..2] (32 bits each); snapshot registers drive the outputs.
- FSM: IDLE -> UPD0 -> UPD1 -> UPD2 -> SNAP -> IDLE. UPDk/SNAP each last exactly one cycle.
- IDLE: frame_start=1 -> UPD0; otherwise stay.
- UPDk: one shared integrator computes, per axis, a 17-bit signed sum = {1'b0,pos} + sign-extended vel.
  - sum < 0 -> 0.
  - sum > XMAX (x) or YMAX (y) -> that max.
  - else sum[15:0].
  - Result written to pos[k].
- Velocity arbitration:
  - vel_wr_en with sel≠3 writes vel[sel] next cycle, in any state.
  - If sel==k during UPDk, the integrator uses vel_wr_data (bypass) and vel[k] takes vel_wr_data, subject to the bounce rule.
  - sel==3 is a no-op.
- SNAP: all six snapshot registers load from pos/vel as they stand at the start of SNAP. A velocity write in the SNAP cycle lands internally but is not in this snapshot.
- frame_start in any state other than IDLE: ignored, overrun<=1.
- overrun_clr and an overrun set in the same cycle: set wins.
- Reset mid-sequence aborts immediately to IDLE; no partial snapshot is published.

## Timing

- frame_start at cycle N (IDLE): UPD0 N+1, UPD1 N+2, UPD2 N+3, SNAP N+4.
- Outputs change and snap_valid=1 in cycle N+5 only. The FSM is in IDLE at N+5, so frame_start at N+5 is accepted.
- busy=1 in cycles N+1..N+4 (registered from state).
- Velocity-write latency: 1 cycle internally; visible on outputs only after the next SNAP.
- Reset values: all pos, vel and snapshot outputs 32'h0; busy=0, snap_valid=0, overrun=0; state IDLE.

## Configuration

- PHYS_BOUNCE_EN defined: in UPD2 (ball only), any axis that clamps has its stored velocity component negated. Negating -32768 gives +32767. A bypassed write value is negated likewise.
- PHYS_BOUNCE_EN undefined: clamp only, velocities never modified by the scheduler.
- Players never bounce in either build.

## Test plan

- Reset, then one frame_start with all velocities 0 -> snap_valid at N+5, all outputs 32'h0, busy high N+1..N+4.
- Write p1 vel {+5,-3} at pos {100,50}, frame_start -> p1_pos={105,47}, p1_vel={5,-3} after N+5.
- Ball pos {637,2}, vel {+4,-5}, frame -> b1_pos={639,0}.
  - With PHYS_BOUNCE_EN: b1_vel={-4,+5}.
  - Without: b1_vel={4,-5}.
- vel_wr sel=1 data {+10,0} asserted exactly in UPD1, p2 pos {0,0} -> p2_pos={10,0}, p2_vel={10,0}.
- frame_start at N+2 -> overrun=1, sequence completes at N+5 unchanged. overrun_clr pulse with a simultaneous frame_start while busy -> overrun stays 1.
- Assert Reset during UPD1 -> outputs 0, no snap_valid, busy=0. A frame_start after deassertion runs normally.
